// File: rtl/read2mac_control.sv
// rtl/read2mac_control.sv - read-side line buffer drain controller feeding the MAC mesh
module read2mac_control #(
    parameter int X_MAC    = 4,
    parameter int X_MESH   = 16,
    parameter int ADDR_LEN = 13,
    parameter int DATA_LEN = 32,
    localparam int BUFFER_NUM = X_MAC * X_MESH,
    localparam int DATAWIDTH  = BUFFER_NUM * DATA_LEN,
    localparam int ADDRWIDTH  = BUFFER_NUM * ADDR_LEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 conf,
    input  logic [ADDR_LEN-1:0]  st_addr,
    input  logic [7:0]           linelen,
    input  logic [7:0]           line_num,
    input  logic [ADDR_LEN-1:0]  line_stride,
    input  logic [1:0]           valid_mac,
    output logic [ADDRWIDTH-1:0] addrb,
    output logic                 enb,
    input  logic [DATAWIDTH-1:0] doutb,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam int FIFO_DEPTH = 4;

    logic [1:0]          state_q, state_d;
    logic [7:0]          len_q, len_d, num_q, num_d;
    logic [ADDR_LEN-1:0] stride_q, stride_d;
    logic [1:0]          vmac_q, vmac_d;
    logic [7:0]          w_q, w_d, l_q, l_d;
    logic [ADDR_LEN-1:0] base_q, base_d;
    logic                enb_q, enb_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic                rd_last_q, rd_last_d;
    logic                dv_q, dv_d;
    logic                dv_last_q, dv_last_d;
    logic [DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATAWIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem_q, last_mem_d;
    logic [1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]          count_q, count_d;
    logic                done_q, done_d;

    logic [DATAWIDTH-1:0] cap_data;
    logic [7:0]          cur_w, cur_l, cur_len, cur_num;
    logic [ADDR_LEN-1:0] cur_base, cur_stride;
    logic [2:0]          inflight;
    logic                issue, push, pop;

    // Zero the MAC lanes above the latched valid_mac before data enters the FIFO
    always_comb begin
        cap_data = doutb;
        for (int i = 0; i < X_MESH; i++) begin
            for (int j = 0; j < X_MAC; j++) begin
                if (j > int'(vmac_q)) begin
                    cap_data[(j + i * X_MAC) * DATA_LEN +: DATA_LEN] = '0;
                end
            end
        end
    end

    // Job sequencing, read issue with FIFO credit check, FIFO push/pop and completion
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        num_d      = num_q;
        stride_d   = stride_q;
        vmac_d     = vmac_q;
        w_d        = w_q;
        l_d        = l_q;
        base_d     = base_q;
        enb_d      = 1'b0;
        addr_d     = addr_q;
        rd_last_d  = 1'b0;
        dv_d       = enb_q;
        dv_last_d  = rd_last_q;
        mem_d      = mem_q;
        last_mem_d = last_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        cur_w      = w_q;
        cur_l      = l_q;
        cur_len    = len_q;
        cur_num    = num_q;
        cur_base   = base_q;
        cur_stride = stride_q;
        // Reads on enb and reads landing on doutb both hold a future FIFO slot
        inflight   = {2'b00, enb_q} + {2'b00, dv_q};

        case (state_q)
            ST_IDLE: begin
                if (conf) begin
                    len_d    = linelen;
                    num_d    = line_num;
                    stride_d = line_stride;
                    vmac_d   = valid_mac;
                    if (linelen == 8'd0 || line_num == 8'd0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        // First read goes out straight from the conf cycle
                        issue      = 1'b1;
                        cur_w      = 8'd0;
                        cur_l      = 8'd0;
                        cur_len    = linelen;
                        cur_num    = line_num;
                        cur_base   = st_addr;
                        cur_stride = line_stride;
                        state_d    = ST_READ;
                    end
                end
            end
            ST_READ: begin
                issue = (count_q + inflight) < 3'd4;
            end
            default: ;
        endcase

        if (issue) begin
            enb_d     = 1'b1;
            addr_d    = cur_base + ADDR_LEN'(cur_w);
            rd_last_d = (cur_w == cur_len - 8'd1);
            if (cur_w == cur_len - 8'd1) begin
                w_d    = 8'd0;
                l_d    = cur_l + 8'd1;
                base_d = cur_base + cur_stride;
                if (cur_l == cur_num - 8'd1) begin
                    state_d = ST_DRAIN;
                end
            end else begin
                w_d    = cur_w + 8'd1;
                l_d    = cur_l;
                base_d = cur_base;
            end
        end

        push = dv_q;
        pop  = (count_q != 3'd0) && out_ready;
        if (push) begin
            mem_d[wr_ptr_q]      = cap_data;
            last_mem_d[wr_ptr_q] = dv_last_q;
            wr_ptr_d             = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, push} - {2'b00, pop};

        // Finish once nothing is queued and nothing can still arrive next cycle
        if (state_q == ST_DRAIN && !enb_q && count_d == 3'd0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            num_q      <= '0;
            stride_q   <= '0;
            vmac_q     <= '0;
            w_q        <= '0;
            l_q        <= '0;
            base_q     <= '0;
            enb_q      <= 1'b0;
            addr_q     <= '0;
            rd_last_q  <= 1'b0;
            dv_q       <= 1'b0;
            dv_last_q  <= 1'b0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            last_mem_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            num_q      <= num_d;
            stride_q   <= stride_d;
            vmac_q     <= vmac_d;
            w_q        <= w_d;
            l_q        <= l_d;
            base_q     <= base_d;
            enb_q      <= enb_d;
            addr_q     <= addr_d;
            rd_last_q  <= rd_last_d;
            dv_q       <= dv_d;
            dv_last_q  <= dv_last_d;
            mem_q      <= mem_d;
            last_mem_q <= last_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

    assign addrb     = {BUFFER_NUM{addr_q}};
    assign enb       = enb_q;
    assign out_valid = (count_q != 3'd0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_last  = out_valid & last_mem_q[rd_ptr_q];
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_read2mac_control.sv
// tb/tb_read2mac_control.sv - directed self-checking bench for read2mac_control
module tb_read2mac_control;

    localparam int X_MAC = 4;
    localparam int BN    = 64;
    localparam int DW    = BN * 32;
    localparam int AW    = BN * 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          conf = 1'b0;
    logic [12:0]   st_addr = '0;
    logic [7:0]    linelen = '0;
    logic [7:0]    line_num = '0;
    logic [12:0]   line_stride = '0;
    logic [1:0]    valid_mac = '0;
    logic [AW-1:0] addrb;
    logic          enb;
    logic [DW-1:0] doutb = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          done;

    bit            all_ones = 1'b0;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;

    logic [12:0]   addr_log[$];
    int            enb_cyc[$];
    logic [DW-1:0] pop_data[$];
    bit            pop_last[$];
    int            pop_cyc[$];
    int            done_cyc[$];
    bit            done_busy[$];
    logic [12:0]   exp_addr[$];

    read2mac_control dut (
        .clk(clk), .rst_n(rst_n), .conf(conf), .st_addr(st_addr), .linelen(linelen),
        .line_num(line_num), .line_stride(line_stride), .valid_mac(valid_mac),
        .addrb(addrb), .enb(enb), .doutb(doutb), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] raw_word(input logic [12:0] a, input int b);
        return {3'b000, a, 8'(b), 8'hA5};
    endfunction

    function automatic logic [DW-1:0] exp_word(input logic [12:0] a, input int vmac, input bit ones);
        logic [DW-1:0] v;
        for (int b = 0; b < BN; b++) begin
            if ((b % X_MAC) > vmac) v[b*32 +: 32] = 32'h0;
            else v[b*32 +: 32] = ones ? 32'hFFFF_FFFF : raw_word(a, b);
        end
        return v;
    endfunction

    function automatic int diff_lane(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int i = 0; i < BN; i++) if (a[i*32 +: 32] !== b[i*32 +: 32]) return i;
        return 0;
    endfunction

    // Buffer model: one-cycle read latency, garbage when not enabled
    always @(posedge clk) begin
        for (int b = 0; b < BN; b++) begin
            doutb[b*32 +: 32] <= (enb === 1'b1) ? (all_ones ? 32'hFFFF_FFFF : raw_word(addrb[12:0], b))
                                                : 32'hDEAD_0000;
        end
    end

    // Event log, sampled mid-cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (enb === 1'b1) begin
            addr_log.push_back(addrb[12:0]);
            enb_cyc.push_back(cyc);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            pop_data.push_back(out_data);
            pop_last.push_back(out_last);
            pop_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_busy.push_back(busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete(); enb_cyc.delete(); pop_data.delete(); pop_last.delete();
        pop_cyc.delete(); done_cyc.delete(); done_busy.delete();
    endtask

    task automatic build_exp(input int st, input int len, input int num, input int stride);
        exp_addr.delete();
        for (int l = 0; l < num; l++)
            for (int w = 0; w < len; w++)
                exp_addr.push_back(13'(st + l * stride + w));
    endtask

    task automatic start_job(input logic [12:0] st, input logic [7:0] len, input logic [7:0] num,
                             input logic [12:0] stride, input logic [1:0] vm, output int t);
        tick();
        st_addr = st; linelen = len; line_num = num; line_stride = stride; valid_mac = vm;
        conf = 1'b1;
        t = cyc + 1;
        tick();
        conf = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cyc.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({enb, out_valid, out_last, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {enb, out_valid, out_last, busy, done});
        end
        checks++;
        if (addrb !== '0) begin failures++; $display("FAIL reset_addrb got=%0h exp=0", addrb[12:0]); end
        checks++;
        if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got_lo=%0h exp=0", out_data[63:0]); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int t, ln;
        logic [AW-1:0] exp_ab;
        logic [DW-1:0] ew;
        clear_logs();
        build_exp(13'h010, 3, 2, 8);
        start_job(13'h010, 8'd3, 8'd2, 13'd8, 2'd3, t);
        exp_ab = {BN{13'h010}};
        checks++;
        if (busy !== 1'b1 || enb !== 1'b1 || addrb !== exp_ab) begin
            failures++;
            $display("FAIL basic_first_issue busy=%b enb=%b addr=%0h exp busy=1 enb=1 addr=010 broadcast", busy, enb, addrb[12:0]);
        end
        wait_done(40);
        checks++;
        if (addr_log.size() != 6 || pop_cyc.size() != 6) begin
            failures++;
            $display("FAIL basic_counts reads=%0d pops=%0d exp=6/6", addr_log.size(), pop_cyc.size());
        end
        for (int k = 0; k < 6 && k < addr_log.size() && k < pop_cyc.size(); k++) begin
            checks++;
            if (addr_log[k] !== exp_addr[k] || enb_cyc[k] != t + 1 + k) begin
                failures++;
                $display("FAIL basic_read[%0d] addr=%0h cyc=%0d exp addr=%0h cyc=%0d", k, addr_log[k], enb_cyc[k] - t, exp_addr[k], 1 + k);
            end
            ew = exp_word(exp_addr[k], 3, 1'b0);
            ln = diff_lane(pop_data[k], ew);
            checks++;
            if (pop_data[k] !== ew || pop_last[k] !== (k % 3 == 2) || pop_cyc[k] != t + 3 + k) begin
                failures++;
                $display("FAIL basic_pop[%0d] lane%0d=%0h last=%b cyc=%0d exp lane%0d=%0h last=%b cyc=%0d",
                         k, ln, pop_data[k][ln*32 +: 32], pop_last[k], pop_cyc[k] - t, ln, ew[ln*32 +: 32], (k % 3 == 2), 3 + k);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != t + 9 || done_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL basic_done n=%0d cyc=%0d exp n=1 cyc=9 busy_low", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - t : -1);
        end
    endtask

    task automatic test_mask();
        int t;
        logic [DW-1:0] ew;
        clear_logs();
        all_ones = 1'b1;
        start_job(13'h000, 8'd2, 8'd1, 13'd0, 2'd1, t);
        wait_done(30);
        all_ones = 1'b0;
        ew = exp_word(13'h0, 1, 1'b1);
        checks++;
        if (pop_data.size() != 2) begin failures++; $display("FAIL mask_pops got=%0d exp=2", pop_data.size()); end
        for (int k = 0; k < pop_data.size(); k++) begin
            checks++;
            if (pop_data[k][31:0] !== 32'hFFFF_FFFF || pop_data[k][63:32] !== 32'hFFFF_FFFF ||
                pop_data[k][95:64] !== 32'h0 || pop_data[k][127:96] !== 32'h0 || pop_data[k] !== ew) begin
                failures++;
                $display("FAIL mask_word[%0d] col0 lanes=%0h exp=00000000_00000000_ffffffff_ffffffff", k, pop_data[k][127:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int t, ln;
        logic [DW-1:0] ew;
        clear_logs();
        build_exp(13'h100, 10, 1, 0);
        out_ready = 1'b0;
        start_job(13'h100, 8'd10, 8'd1, 13'd0, 2'd2, t);
        repeat (12) tick();
        checks++;
        if (addr_log.size() != 4 || pop_cyc.size() != 0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall reads=%0d pops=%0d valid=%b exp reads=4 pops=0 valid=1", addr_log.size(), pop_cyc.size(), out_valid);
        end
        out_ready = 1'b1;
        wait_done(60);
        checks++;
        if (addr_log.size() != 10 || pop_cyc.size() != 10) begin
            failures++;
            $display("FAIL bp_counts reads=%0d pops=%0d exp=10/10", addr_log.size(), pop_cyc.size());
        end
        checks++;
        if (enb_cyc.size() < 5 || pop_cyc.size() < 1 || enb_cyc[4] != pop_cyc[0] + 2) begin
            failures++;
            $display("FAIL bp_resume enb5_after_pop=%0d exp=2", (enb_cyc.size() >= 5 && pop_cyc.size() >= 1) ? enb_cyc[4] - pop_cyc[0] : -1);
        end
        for (int k = 0; k < 10 && k < addr_log.size() && k < pop_cyc.size(); k++) begin
            ew = exp_word(exp_addr[k], 2, 1'b0);
            ln = diff_lane(pop_data[k], ew);
            checks++;
            if (addr_log[k] !== exp_addr[k] || pop_data[k] !== ew || pop_last[k] !== (k == 9) ||
                pop_cyc[k] != pop_cyc[0] + k) begin
                failures++;
                $display("FAIL bp_word[%0d] addr=%0h lane%0d=%0h last=%b exp addr=%0h lane=%0h last=%b",
                         k, addr_log[k], ln, pop_data[k][ln*32 +: 32], pop_last[k], exp_addr[k], ew[ln*32 +: 32], (k == 9));
            end
        end
        checks++;
        if (done_cyc.size() != 1 || pop_cyc.size() != 10 || done_cyc[0] != pop_cyc[9] + 1) begin
            failures++;
            $display("FAIL bp_done n=%0d exp n=1 one cycle after pop 10", done_cyc.size());
        end
    endtask

    task automatic test_wrap();
        int t;
        logic [DW-1:0] ew;
        clear_logs();
        build_exp(13'h1FFE, 4, 1, 0);
        start_job(13'h1FFE, 8'd4, 8'd1, 13'd0, 2'd3, t);
        wait_done(30);
        checks++;
        if (addr_log.size() != 4 || pop_data.size() != 4) begin
            failures++;
            $display("FAIL wrap_counts reads=%0d pops=%0d exp=4/4", addr_log.size(), pop_data.size());
        end
        for (int k = 0; k < 4 && k < addr_log.size() && k < pop_data.size(); k++) begin
            ew = exp_word(exp_addr[k], 3, 1'b0);
            checks++;
            if (addr_log[k] !== exp_addr[k] || pop_data[k] !== ew) begin
                failures++;
                $display("FAIL wrap_addr[%0d] got=%0h exp=%0h word0=%0h", k, addr_log[k], exp_addr[k], pop_data[k][31:0]);
            end
        end
    endtask

    task automatic test_degenerate();
        int t;
        for (int v = 0; v < 2; v++) begin
            clear_logs();
            start_job(13'h050, (v == 0) ? 8'd0 : 8'd4, (v == 0) ? 8'd3 : 8'd0, 13'd1, 2'd3, t);
            wait_done(20);
            checks++;
            if (addr_log.size() != 0 || pop_cyc.size() != 0 || done_cyc.size() != 1 || done_cyc[0] != t + 2) begin
                failures++;
                $display("FAIL degenerate[%0d] reads=%0d dones=%0d done_at=%0d exp reads=0 dones=1 done_at=2",
                         v, addr_log.size(), done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - t : -1);
            end
        end
    endtask

    task automatic test_ignored_conf();
        int t;
        logic [DW-1:0] ew;
        clear_logs();
        build_exp(13'h040, 3, 2, 4);
        start_job(13'h040, 8'd3, 8'd2, 13'd4, 2'd3, t);
        tick();
        st_addr = 13'h700; linelen = 8'd1; line_num = 8'd1; line_stride = 13'd0; valid_mac = 2'd0;
        conf = 1'b1;
        tick();
        conf = 1'b0;
        wait_done(40);
        repeat (10) tick();
        checks++;
        if (done_cyc.size() != 1 || addr_log.size() != 6 || pop_data.size() != 6) begin
            failures++;
            $display("FAIL ignored_conf dones=%0d reads=%0d pops=%0d exp 1/6/6", done_cyc.size(), addr_log.size(), pop_data.size());
        end
        for (int k = 0; k < 6 && k < addr_log.size() && k < pop_data.size(); k++) begin
            ew = exp_word(exp_addr[k], 3, 1'b0);
            checks++;
            if (addr_log[k] !== exp_addr[k] || pop_data[k] !== ew) begin
                failures++;
                $display("FAIL ignored_word[%0d] addr=%0h lane3=%0h exp addr=%0h lane3=%0h",
                         k, addr_log[k], pop_data[k][127:96], exp_addr[k], ew[127:96]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t, ln;
        logic [DW-1:0] ew;
        clear_logs();
        start_job(13'h200, 8'd8, 8'd2, 13'h010, 2'd3, t);
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({enb, out_valid, out_last, busy, done} !== 5'b0 || addrb !== '0 || out_data !== '0) begin
            failures++;
            $display("FAIL midreset_outputs flags=%b addr=%0h data_lo=%0h exp all zero",
                     {enb, out_valid, out_last, busy, done}, addrb[12:0], out_data[63:0]);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({enb, out_valid, busy} !== 3'b0) begin
            failures++;
            $display("FAIL midreset_flush enb/valid/busy=%b exp=000", {enb, out_valid, busy});
        end
        repeat (3) tick();
        clear_logs();
        build_exp(13'h123, 2, 3, 13'h020);
        start_job(13'h123, 8'd2, 8'd3, 13'h020, 2'd0, t);
        wait_done(40);
        checks++;
        if (addr_log.size() != 6 || pop_data.size() != 6 || done_cyc.size() != 1 || done_cyc[0] != t + 9) begin
            failures++;
            $display("FAIL midreset_rerun reads=%0d pops=%0d dones=%0d exp 6/6/1 done_at=9", addr_log.size(), pop_data.size(), done_cyc.size());
        end
        for (int k = 0; k < 6 && k < addr_log.size() && k < pop_data.size(); k++) begin
            ew = exp_word(exp_addr[k], 0, 1'b0);
            ln = diff_lane(pop_data[k], ew);
            checks++;
            if (addr_log[k] !== exp_addr[k] || pop_data[k] !== ew || pop_last[k] !== (k % 2 == 1)) begin
                failures++;
                $display("FAIL midreset_word[%0d] addr=%0h lane%0d=%0h last=%b exp addr=%0h lane=%0h last=%b",
                         k, addr_log[k], ln, pop_data[k][ln*32 +: 32], pop_last[k], exp_addr[k], ew[ln*32 +: 32], (k % 2 == 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_backpressure();
        test_wrap();
        test_degenerate();
        test_ignored_conf();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
